// File: rtl/cond_inv_pipe.sv
// Pipelined WIDTH-bit conditional inverter for the ALU datapath. A free-running
// 4-phase power-clock sequencer gates every pipeline advance to the EVAL phase.
module cond_inv_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clkpos,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [1:0]                   mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out,
    output logic [1:0]                   phase,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int OW = $clog2(DEPTH + 1);

    localparam logic [1:0] PH_EVAL    = 2'd0;
    localparam logic [1:0] PH_HOLD    = 2'd1;
    localparam logic [1:0] PH_RECOVER = 2'd2;
    localparam logic [1:0] PH_WAIT    = 2'd3;

    localparam logic [1:0] MODE_XOR  = 2'b00;
    localparam logic [1:0] MODE_CINV = 2'b01;
    localparam logic [1:0] MODE_PASS = 2'b10;

    logic [DEPTH-1:0] s_valid;
    logic [WIDTH-1:0] s_data [DEPTH];
    logic [WIDTH-1:0] op_result;
    logic             advance;
    logic             xfer;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        op_result = ~(a ^ b);
        case (mode)
            MODE_XOR:  op_result = a ^ b;
            MODE_CINV: op_result = b[0] ? ~a : a;
            MODE_PASS: op_result = a;
            default:   op_result = ~(a ^ b);
        endcase
    end

    assign advance   = (phase == PH_EVAL) && (!out_valid || out_ready);
    assign xfer      = advance && out_valid;
    assign in_ready  = advance && !rst;
    assign out       = s_data[DEPTH-1];
    assign out_valid = s_valid[DEPTH-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            phase <= PH_EVAL;
        end else begin
            case (phase)
                PH_EVAL:    phase <= PH_HOLD;
                PH_HOLD:    phase <= PH_RECOVER;
                PH_RECOVER: phase <= PH_WAIT;
                default:    phase <= PH_EVAL;
            endcase
        end
    end

    // NOTE: the stage data array is reset too, because out must read 0 the
    // moment rst rises; otherwise data-only storage could skip the reset.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            s_valid <= '0;
            for (int k = 0; k < DEPTH; k++) s_data[k] <= '0;
        end else if (advance) begin
            s_valid[0] <= in_valid;
            s_data[0]  <= op_result;
            for (int k = 1; k < DEPTH; k++) begin
                s_valid[k] <= s_valid[k-1];
                s_data[k]  <= s_data[k-1];
            end
        end
    end

    // Occupancy moves only on advance edges; a simultaneous accept and transfer cancel.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (advance) begin
            if (in_valid && !xfer)
                occ <= occ + OW'(1);
            else if (!in_valid && xfer)
                occ <= occ - OW'(1);
        end
    end

endmodule

// File: tb/tb_cond_inv_pipe.sv
// Scoreboard bench for cond_inv_pipe: expected words are queued at acceptance and
// compared while they sit at the output; phase, occupancy and handshake are modelled.
module tb_cond_inv_pipe;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int OW = $clog2(D + 1);

    logic          clkpos = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic [1:0]    phase;
    logic [OW-1:0] occ;

    cond_inv_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clkpos(clkpos), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .phase(phase), .occ(occ)
    );

    always #5 clkpos = ~clkpos;

    int n_cmp = 0;
    int n_bad = 0;

    logic [D-1:0] mv;
    logic [W-1:0] sb[$];
    logic [1:0]   mph;
    bit           acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [1:0] m);
        case (m)
            2'b00:   return x ^ y;
            2'b01:   return y[0] ? ~x : x;
            2'b10:   return x;
            default: return ~(x ^ y);
        endcase
    endfunction

    // One clock: check handshake before the edge, update model, check outputs after.
    task automatic step();
        logic adv;
        #1;
        adv = (mph == 2'd0) && (!mv[D-1] || out_ready);
        check("in_ready", in_ready, adv);
        @(posedge clkpos);
        acc = adv && in_valid;
        if (adv) begin
            if (mv[D-1]) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else void'(sb.pop_front());
            end
            mv = {mv[D-2:0], in_valid};
            if (in_valid) sb.push_back(ref_op(a, b, mode));
        end
        mph = mph + 2'd1;
        @(negedge clkpos);
        check("phase", phase, mph);
        check("out_valid", out_valid, mv[D-1]);
        check("occ", occ, $countones(mv));
        if (mv[D-1]) begin
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else check("out", out, sb[0]);
        end
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] mv_);
        acc = 1'b0;
        in_valid = 1'b1; a = av; b = bv; mode = mv_;
        for (int k = 0; k < 40; k++) begin
            step();
            if (acc) break;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 100 && mv != '0; k++) step();
        check("drain_timeout", mv, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 2'b00; out_ready = 1'b0;
        mv = '0; mph = 2'd0;
        repeat (2) @(negedge clkpos);
        check("rst_in_ready", in_ready, 0);
        check("rst_phase", phase, 0);
        check("rst_occ", occ, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        rst = 1'b0;

        // First edge after reset is EVAL: accept immediately, 12-cycle latency.
        out_ready = 1'b1;
        send(8'hA5, 8'h0F, 2'b00);
        check("first_accept", acc, 1);
        repeat (11) step();
        check("lat_early_valid", out_valid, 0);
        step();
        check("lat_valid", out_valid, 1);
        check("lat_out", out, 8'hAA);
        check("lat_occ", occ, 1);
        drain();

        // Mode vectors; presented off-EVAL first so capture-once is exercised.
        idle(1);
        send(8'h3C, 8'h01, 2'b01);
        idle(2);
        send(8'h3C, 8'hFE, 2'b01);
        idle(1);
        send(8'hA5, 8'h0F, 2'b11);
        send(8'h5A, 8'hFF, 2'b10);
        drain();

        // Back-to-back with random modes.
        for (int i = 0; i < 8; i++)
            send(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
        drain();

        // Fill with downstream stalled, hold for 3 EVAL periods, then release.
        out_ready = 1'b0;
        send(8'h11, 8'h22, 2'b00);
        send(8'h33, 8'h01, 2'b01);
        send(8'h55, 8'h00, 2'b10);
        send(8'h77, 8'h0F, 2'b11);
        in_valid = 1'b1; a = 8'h99; b = 8'h66; mode = 2'b00;
        repeat (12) step();
        check("stall_occ", occ, 4);
        check("stall_valid", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Async reset mid-flight with three words in flight and out_valid high.
        send(8'h01, 8'h02, 2'b00);
        send(8'h03, 8'h04, 2'b11);
        send(8'h05, 8'h01, 2'b01);
        for (int k = 0; k < 20 && !mv[D-1]; k++) step();
        check("pre_rst_occ", occ, 3);
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out", out, 0);
        check("arst_occ", occ, 0);
        check("arst_phase", phase, 0);
        check("arst_in_ready", in_ready, 0);
        mv = '0; mph = 2'd0; sb.delete();
        @(negedge clkpos);
        rst = 1'b0;
        send(8'hC3, 8'hFF, 2'b00);
        check("post_rst_accept_first", acc, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cond_inv_pipe.md
Name: cond_inv_pipe

Overview:
Parametrised, pipelined successor to the single-bit adiabatic conditional inverter cell. It applies a WIDTH-bit conditional inversion of operand a under control of operand b and a mode select, then carries the result through a DEPTH-stage pipeline. Pipeline advance is gated by a free-running 4-phase adiabatic power-clock sequencer (EVAL, HOLD, RECOVER, WAIT). It sits in the MIPS25 ALU datapath between operand fetch and the adder/logic-unit result mux, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DEPTH, 4, number of pipeline stages (>=1)

Ports:
clkpos  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  block accepts a word this cycle
a  input  WIDTH  data operand
b  input  WIDTH  inversion-control operand
mode  input  2  operation select, captured with the word
out_valid  output  1  out holds a valid result
out_ready  input  1  downstream accepts the result
out  output  WIDTH  result of the last stage
phase  output  2  current power-clock phase: 0 EVAL, 1 HOLD, 2 RECOVER, 3 WAIT
occ  output  $clog2(DEPTH+1)  number of valid words in the pipeline

Behaviour:
- Reset (async, active-high): phase=0 (EVAL); all stage valid bits=0; all stage data=0; out=0; out_valid=0; occ=0; in_ready=0 while rst is high.
- Phase sequencer: increments every clkpos edge, 0->1->2->3->0. It is never stalled by the handshake.
- advance = (phase==0) && (!out_valid || out_ready). in_ready = advance (combinational).
- Operation applied at capture into stage 0, per bit i:
  - mode 00: a[i]^b[i] (XOR, the base cell's function)
  - mode 01: b[0] ? ~a : a (whole-word conditional invert; b[WIDTH-1:1] ignored)
  - mode 10: a (pass)
  - mode 11: ~(a[i]^b[i]) (XNOR)
- On an advance edge:
  - s[0] <= {in_valid, op(a,b,mode)}
  - s[k] <= s[k-1] for k = 1..DEPTH-1
  - the word in s[DEPTH-1] is consumed if out_valid && out_ready
- With no advance, all stages hold. in_valid/a/b/mode are ignored and no transfer occurs.
- Bubbles are not compressed. A stage with valid=0 shifts like a word.
- out = s[DEPTH-1].data; out_valid = s[DEPTH-1].valid. Both are registered and stable across HOLD/RECOVER/WAIT.
- Latency: a word accepted on EVAL edge E0 appears at out (out_valid=1) after edge E0+(DEPTH-1) EVAL periods, i.e. 4*(DEPTH-1) clkpos cycles with no stall. For DEPTH=1 it appears on the accept edge itself.
- Throughput: at most one word per 4 cycles.
- Stall: out_valid=1 && out_ready=0 at EVAL means no advance. The whole pipe holds and in_ready=0. out_ready outside EVAL has no effect.
- out_ready may be high while out_valid=0. The pipe advances normally.
- occ: +1 on an advance with in_valid=1, -1 on a transfer, unchanged when both happen together. Range is 0..DEPTH.
- Reset asserted mid-operation flushes all words immediately and phase returns to 0.
- After rst deasserts, the first clkpos edge is an EVAL edge, so a word may be accepted on it.

Test Plan:
- WIDTH=8, DEPTH=4. Reset, then in_valid=1, a=0xA5, b=0x0F, mode=00 at phase 0, out_ready=1 -> in_ready=1; out_valid rises 12 cycles after the accept edge with out=0xAA, occ=1 until the next EVAL transfer.
- Mode 01: a=0x3C, b=0x01 -> out=0xC3. Then a=0x3C, b=0xFE -> out=0x3C. Mode 11: a=0xA5, b=0x0F -> 0x55. Mode 10: a=0x5A -> 0x5A.
- Back-to-back: in_valid held high with four distinct words, out_ready=1 -> one word accepted every 4 cycles, results in order, occ saturates at 4, no loss.
- Stall: fill the pipe, drive out_ready=0 for 3 EVAL periods -> out, out_valid and all stages hold; in_ready=0; occ=4. Release -> resumes in order.
- in_valid=1 while phase is 1, 2 or 3 -> in_ready=0 and the word is not captured. The same word still presented at the next phase 0 -> captured once.
- Assert rst asynchronously with occ=3 and out_valid=1 -> out_valid=0, out=0, occ=0, phase=0 immediately, with no clkpos edge required.
